// File: rtl/sensor_frame_packer_if.sv
// Sensor-side and SPI-side signal bundle for sensor_frame_packer.
// master: the packer (drives ack, SPI write strobe/word and status).
// slave: the surrounding logic (drives sample set, data_ready, tx_ready).
interface sensor_frame_packer_if #(
  parameter int DW = 64
);
  logic [DW-1:0] data_in;
  logic          data_ready;
  logic          ack;
  logic          spi_tx_ready;
  logic          spi_write;
  logic [15:0]   spi_out;
  logic          busy;
  logic [7:0]    frame_count;
  logic          overrun;

  modport master (
    input  data_in, data_ready, spi_tx_ready,
    output ack, spi_write, spi_out, busy, frame_count, overrun
  );

  modport slave (
    output data_in, data_ready, spi_tx_ready,
    input  ack, spi_write, spi_out, busy, frame_count, overrun
  );
endinterface

// File: rtl/sensor_frame_packer.sv
// Snapshots a sensor sample set and serialises it as header + payload [+ checksum] 16-bit SPI words.
// Latency: ack on the capture edge, header one edge later, then one word every other cycle.
// Backpressure: spi_tx_ready low stalls the current word indefinitely; samples offered while busy set overrun.
// Optional feature macro: FRAME_CHECKSUM_EN (adds CSUM state sending the 16-bit sum of payload words).
module sensor_frame_packer #(
  parameter int SENSORS  = 1,
  parameter int BITWIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,   // async, active-low
  sensor_frame_packer_if.master io_bus
);

  localparam int DW    = 2 * SENSORS * BITWIDTH;
  localparam int WORDS = DW / 16;
  localparam int KW    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(WORDS - 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_PAY} state_t;
`endif

  state_t          r_state;
  logic [DW-1:0]   r_shadow;
  logic [KW-1:0]   r_k;
  logic            r_ack;
  logic            r_spi_write;
  logic [15:0]     r_spi_out;
  logic            r_busy;
  logic [7:0]      r_frame_count;
  logic            r_overrun;
`ifdef FRAME_CHECKSUM_EN
  logic [15:0]     r_csum;
`endif

  logic            w_wr_ok;
  logic [15:0]     w_words [WORDS];
  logic [15:0]     w_pay_word;

  // Word j of the payload, most significant word first.
  for (genvar j = 0; j < WORDS; j++) begin : g_word
    assign w_words[j] = r_shadow[(WORDS-1-j)*16 +: 16];
  end

  // A write needs the slave ready and an idle cycle after the previous write.
  assign w_wr_ok    = io_bus.spi_tx_ready && !r_spi_write;
  assign w_pay_word = w_words[r_k];

  assign io_bus.ack         = r_ack;
  assign io_bus.spi_write   = r_spi_write;
  assign io_bus.spi_out     = r_spi_out;
  assign io_bus.busy        = r_busy;
  assign io_bus.frame_count = r_frame_count;
  assign io_bus.overrun     = r_overrun;

  // Frame FSM with all outputs registered; reset abandons any frame in flight.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state       <= ST_IDLE;
      r_shadow      <= '0;
      r_k           <= '0;
      r_ack         <= 1'b0;
      r_spi_write   <= 1'b0;
      r_spi_out     <= '0;
      r_busy        <= 1'b0;
      r_frame_count <= '0;
      r_overrun     <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      r_csum        <= '0;
`endif
    end else begin
      r_ack       <= 1'b0;
      r_spi_write <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (io_bus.data_ready) begin
            r_shadow <= io_bus.data_in;
            r_ack    <= 1'b1;
            r_busy   <= 1'b1;
            r_k      <= '0;
`ifdef FRAME_CHECKSUM_EN
            r_csum   <= '0;
`endif
            r_state  <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (w_wr_ok) begin
            r_spi_write <= 1'b1;
            r_spi_out   <= {8'hA5, r_frame_count};
            r_k         <= '0;
            r_state     <= ST_PAY;
          end
        end

        ST_PAY: begin
          if (w_wr_ok) begin
            r_spi_write <= 1'b1;
            r_spi_out   <= w_pay_word;
`ifdef FRAME_CHECKSUM_EN
            r_csum      <= r_csum + w_pay_word;
`endif
            if (r_k == LAST_K) begin
              r_k <= '0;
`ifdef FRAME_CHECKSUM_EN
              r_state <= ST_CSUM;
`else
              // Last payload word closes the frame.
              r_frame_count <= r_frame_count + 8'd1;
              r_busy        <= 1'b0;
              r_state       <= ST_IDLE;
`endif
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end

`ifdef FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (w_wr_ok) begin
            r_spi_write   <= 1'b1;
            r_spi_out     <= r_csum;
            r_frame_count <= r_frame_count + 8'd1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
`endif

        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // Any sample offered while a frame is in progress is dropped and flagged.
      if (r_state != ST_IDLE && io_bus.data_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sensor_frame_packer.sv
// Directed bench for sensor_frame_packer (SENSORS=1, BITWIDTH=32).
// Expects checksum word only when FRAME_CHECKSUM_EN is defined.
// Observes the SPI side on falling edges; drives inputs 1ns after falling edges.
module tb_sensor_frame_packer;

`ifdef FRAME_CHECKSUM_EN
  localparam int NW = 6;
`else
  localparam int NW = 5;
`endif

  logic clk;
  logic rst;

  sensor_frame_packer_if #(.DW(64)) bus ();

  sensor_frame_packer #(.SENSORS(1), .BITWIDTH(32)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          cyc     = 0;
  int          ack_cnt = 0;
  int          stall_wr = 0;
  logic        stall_win = 1'b0;
  logic [15:0] wr_q [$];
  int          wt_q [$];

  // Record every SPI write and ack pulse away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (bus.spi_write) begin
      wr_q.push_back(bus.spi_out);
      wt_q.push_back(cyc);
      if (stall_win) stall_wr++;
    end
    if (bus.ack) ack_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_q.delete();
    wt_q.delete();
    ack_cnt = 0;
  endtask

  task automatic pulse_sample(input logic [63:0] d);
    bus.data_in    = d;
    bus.data_ready = 1'b1;
    step();
    bus.data_ready = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && wr_q.size() < n; i++) step();
    chk(tag, 32'(wr_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && bus.busy; i++) step();
    chk(tag, 32'(bus.busy), 32'd0);
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] exp [6]);
    chk({tag, "_nwords"}, 32'(wr_q.size()), 32'(NW));
    for (int i = 0; i < NW && i < wr_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(wr_q[i]), 32'(exp[i]));
  endtask

  logic [15:0] exp_f1 [6];
  logic [15:0] exp_f2 [6];
  logic [15:0] exp_f3 [6];
  int          bad_gap;

  initial begin
    bus.data_in      = '0;
    bus.data_ready   = 1'b0;
    bus.spi_tx_ready = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    step(); step();

    // Reset state
    chk("rst_ack",     32'(bus.ack),         32'd0);
    chk("rst_write",   32'(bus.spi_write),   32'd0);
    chk("rst_out",     32'(bus.spi_out),     32'd0);
    chk("rst_busy",    32'(bus.busy),        32'd0);
    chk("rst_fcount",  32'(bus.frame_count), 32'd0);
    chk("rst_overrun", 32'(bus.overrun),     32'd0);
    rst = 1'b1;
    step();

    // 1: basic frame
    exp_f1 = '{16'hA500, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h9E24};
    clear_log();
    pulse_sample(64'h0123_4567_89AB_CDEF);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    wait_idle(100, "t1_done");
    chk("t1_acks", 32'(ack_cnt), 32'd1);
    chk_frame("t1", exp_f1);
    bad_gap = 0;
    for (int i = 1; i < wt_q.size(); i++)
      if (wt_q[i] - wt_q[i-1] != 2) bad_gap++;
    chk("t1_alt_cycles", 32'(bad_gap), 32'd0);
    chk("t1_fcount", 32'(bus.frame_count), 32'd1);

    // 2: backpressure after the 2nd word
    exp_f2 = '{16'hA501, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF, 16'h9E24};
    clear_log();
    pulse_sample(64'h0123_4567_89AB_CDEF);
    wait_words(2, 50, "t2_reach2");
    bus.spi_tx_ready = 1'b0;
    stall_wr  = 0;
    stall_win = 1'b1;
    repeat (10) step();
    stall_win = 1'b0;
    chk("t2_stall_writes", 32'(stall_wr), 32'd0);
    chk("t2_held_out", 32'(bus.spi_out), 32'h0123);
    chk("t2_busy_stalled", 32'(bus.busy), 32'd1);
    bus.spi_tx_ready = 1'b1;
    wait_idle(100, "t2_done");
    chk_frame("t2", exp_f2);
    chk("t2_fcount", 32'(bus.frame_count), 32'd2);

    // 3: sample offered during payload
    exp_f3 = '{16'hA502, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hAAAA};
    clear_log();
    pulse_sample(64'h1111_2222_3333_4444);
    wait_words(2, 50, "t3_reach2");
    bus.data_in    = 64'hDEAD_BEEF_CAFE_F00D;
    bus.data_ready = 1'b1;
    repeat (3) step();
    bus.data_ready = 1'b0;
    chk("t3_overrun", 32'(bus.overrun), 32'd1);
    wait_idle(100, "t3_done");
    chk("t3_acks", 32'(ack_cnt), 32'd1);
    chk_frame("t3", exp_f3);
    step(); step();
    chk("t3_overrun_sticky", 32'(bus.overrun), 32'd1);
    chk("t3_still_idle", 32'(bus.busy), 32'd0);

    // 4: frame counter wrap over 256 back-to-back frames
    rst = 1'b0;
    step();
    chk("t4_rst_overrun", 32'(bus.overrun), 32'd0);
    chk("t4_rst_fcount", 32'(bus.frame_count), 32'd0);
    rst = 1'b1;
    clear_log();
    bus.data_in    = 64'h0;
    bus.data_ready = 1'b1;
    wait_words(256*NW + 1, 256*2*(NW+1) + 100, "t4_reach257");
    bus.data_ready = 1'b0;
    if (wr_q.size() >= 256*NW + 1) begin
      chk("t4_hdr256", 32'(wr_q[255*NW]), 32'h0000_A5FF);
      chk("t4_hdr257", 32'(wr_q[256*NW]), 32'h0000_A500);
    end
    chk("t4_fcount_wrap", 32'(bus.frame_count), 32'd0);
    wait_idle(100, "t4_done");
    chk("t4_fcount_after", 32'(bus.frame_count), 32'd1);
    chk("t4_acks", 32'(ack_cnt), 32'd257);

    // 5: reset in the middle of a frame
    clear_log();
    pulse_sample(64'h0123_4567_89AB_CDEF);
    wait_words(3, 50, "t5_reach3");
    chk("t5_write_before", 32'(bus.spi_write), 32'd1);
    rst = 1'b0;
    #1;
    chk("t5_write_now", 32'(bus.spi_write), 32'd0);
    chk("t5_busy_now", 32'(bus.busy), 32'd0);
    chk("t5_fcount_now", 32'(bus.frame_count), 32'd0);
    step();
    rst = 1'b1;
    step();
    clear_log();
    pulse_sample(64'h0123_4567_89AB_CDEF);
    wait_idle(100, "t5_done");
    if (wr_q.size() > 0) chk("t5_hdr", 32'(wr_q[0]), 32'h0000_A500);
    else chk("t5_hdr_present", 32'd0, 32'd1);
    chk("t5_nwords", 32'(wr_q.size()), 32'(NW));
    chk("t5_fcount", 32'(bus.frame_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
